// File: rtl/cskipa_rr_scheduler.sv
// Round-robin scheduler sharing one carry-skip adder between NREQ requesters.
// The winning requester's operands are summed combinationally and captured in
// a single registered response stage tagged with the requester ID.
module cskipa_rr_scheduler #(
   parameter int WIDTH = 22,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NREQ-1:0]       i_req_valid,
   input  logic [NREQ*WIDTH-1:0] i_req_a,
   input  logic [NREQ*WIDTH-1:0] i_req_b,
   output logic [NREQ-1:0]       o_req_ready,
   output logic                  o_rsp_valid,
   output logic [IDW-1:0]        o_rsp_id,
   output logic [WIDTH-1:0]      o_sum,
   output logic                  o_cout,
   input  logic                  i_rsp_ready
);

   // Operands are padded so at least one spare zero bit sits above WIDTH;
   // the carry out of bit WIDTH-1 then lands in sum bit WIDTH.
   localparam int BLK  = 4;
   localparam int NBLK = WIDTH / BLK + 1;
   localparam int PW   = NBLK * BLK;

   logic [IDW-1:0]   ptr;
   logic [IDW:0]     cand;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic [NREQ-1:0]  grant;
   logic             can_accept;
   logic             fire;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   add_res;

   // Ripple within each 4-bit block; a fully propagating block passes its
   // incoming carry straight through (the skip path).
   function automatic logic [WIDTH:0] cskip_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [PW-1:0] ap;
      logic [PW-1:0] bp;
      logic [PW-1:0] sp;
      logic          c;
      logic          c_blk_in;
      logic          p_blk;
      logic          p;
      logic          g;
      ap = PW'(a);
      bp = PW'(b);
      sp = '0;
      c  = 1'b0;
      for (int blk = 0; blk < NBLK; blk++) begin
         c_blk_in = c;
         p_blk    = 1'b1;
         for (int i = 0; i < BLK; i++) begin
            p = ap[blk*BLK+i] ^ bp[blk*BLK+i];
            g = ap[blk*BLK+i] & bp[blk*BLK+i];
            sp[blk*BLK+i] = p ^ c;
            c     = g | (p & c);
            p_blk = p_blk & p;
         end
         c = p_blk ? c_blk_in : c;
      end
      return sp[WIDTH:0];
   endfunction

   // Search valid bits from ptr upward with wrap; first hit wins.
   always_comb begin
      cand      = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr} + (IDW+1)'(i);
         if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
         if (!grant_any && i_req_valid[cand[IDW-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[IDW-1:0];
         end
      end
   end

   assign grant       = grant_any ? (NREQ'(1) << grant_idx) : '0;
   assign can_accept  = !o_rsp_valid || i_rsp_ready;
   assign fire        = grant_any && can_accept && i_rst_n;
   assign o_req_ready = fire ? grant : '0;

   assign op_a    = i_req_a[int'(grant_idx)*WIDTH +: WIDTH];
   assign op_b    = i_req_b[int'(grant_idx)*WIDTH +: WIDTH];
   assign add_res = cskip_add(op_a, op_b);

   // Response register refills on accept, otherwise drains when consumed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= '0;
         o_sum       <= '0;
         o_cout      <= 1'b0;
         ptr         <= '0;
      end else if (fire) begin
         o_rsp_valid <= 1'b1;
         o_rsp_id    <= grant_idx;
         o_sum       <= add_res[WIDTH-1:0];
         o_cout      <= add_res[WIDTH];
         ptr         <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (i_rsp_ready) begin
         o_rsp_valid <= 1'b0;
      end
   end

endmodule
